// File: rtl/ctrl_scoreboard.sv
// Issue-side scoreboard: RAW/WAW/structural hazard checks, per-unit latency
// tracking and lowest-index arbitration onto one register-file write-back port.
//
// Per-unit state | meaning
// S_IDLE         | unit free, may accept an issue
// S_EXEC         | executing, r_cnt counts remaining cycles
// S_DONE         | result ready, waiting to win the write-back port
module ctrl_scoreboard #(
    parameter int NUM_FU = 4,
    parameter int LAT_W  = 4,
    parameter int FU_W   = $clog2(NUM_FU)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              iss_valid,
    input  logic [FU_W-1:0]   iss_fu,
    input  logic [4:0]        iss_rd,
    input  logic              iss_rd_we,
    input  logic [4:0]        iss_rs1,
    input  logic [4:0]        iss_rs2,
    input  logic              iss_rs1use,
    input  logic              iss_rs2use,
    input  logic [LAT_W-1:0]  iss_lat,
    output logic              iss_ready,
    output logic              stall_raw,
    output logic              stall_waw,
    output logic              stall_struct,
    output logic              wb_valid,
    output logic [FU_W-1:0]   wb_fu,
    output logic [4:0]        wb_rd,
    output logic              wb_we,
    output logic [NUM_FU-1:0] fu_busy
);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_EXEC = 2'd1, S_DONE = 2'd2} fu_state_e;

    fu_state_e        r_state [NUM_FU];
    logic [LAT_W-1:0] r_cnt   [NUM_FU];
    logic [4:0]       r_rd    [NUM_FU];
    logic             r_we    [NUM_FU];
    logic [31:0]      r_pending;

    fu_state_e        w_state_nx [NUM_FU];
    logic [LAT_W-1:0] w_cnt_nx   [NUM_FU];
    logic [4:0]       w_rd_nx    [NUM_FU];
    logic             w_we_nx    [NUM_FU];
    logic             w_fire_fu  [NUM_FU];
    logic [31:0]      w_pending_nx;

    logic             w_any_done;
    logic [FU_W-1:0]  w_win;
    logic [4:0]       w_win_rd;
    logic             w_win_we;
    logic             w_wb_clr;
    logic [31:0]      w_clr_mask;
    logic [31:0]      w_pend_eff;
    logic             w_fu_oor;
    logic             w_fire;
    logic [LAT_W-1:0] w_lat_m1;

    always_comb begin
        w_any_done = 1'b0;
        w_win      = '0;
        w_win_rd   = '0;
        w_win_we   = 1'b0;
        for (int i = NUM_FU - 1; i >= 0; i--) begin
            if (r_state[i] == S_DONE) begin
                w_any_done = 1'b1;
                w_win      = FU_W'(i);
                w_win_rd   = r_rd[i];
                w_win_we   = r_we[i];
            end
        end
    end

    assign wb_valid   = w_any_done & ~flush;
    assign wb_fu      = wb_valid ? w_win    : '0;
    assign wb_rd      = wb_valid ? w_win_rd : '0;
    assign wb_we      = wb_valid & w_win_we;
    assign w_wb_clr   = wb_valid & wb_we & (wb_rd != 5'd0);
    assign w_clr_mask = w_wb_clr ? (32'd1 << wb_rd) : 32'd0;
    // Same-cycle bypass: the register being written back is no longer a hazard.
    assign w_pend_eff = r_pending & ~w_clr_mask;

    assign stall_raw = (iss_rs1use & w_pend_eff[iss_rs1]) | (iss_rs2use & w_pend_eff[iss_rs2]);
    assign stall_waw = iss_rd_we & (iss_rd != 5'd0) & w_pend_eff[iss_rd];
    assign w_fu_oor  = (int'(iss_fu) >= NUM_FU);

    always_comb begin
        stall_struct = w_fu_oor;
        for (int i = 0; i < NUM_FU; i++) begin
            if ((iss_fu == FU_W'(i)) && (r_state[i] != S_IDLE) &&
                !(w_any_done && (w_win == FU_W'(i))))
                stall_struct = 1'b1;
        end
    end

    assign iss_ready = ~stall_raw & ~stall_waw & ~stall_struct & ~flush;
    assign w_fire    = iss_valid & iss_ready;
    assign w_lat_m1  = (iss_lat == '0) ? '0 : iss_lat - LAT_W'(1);

    always_comb begin
        for (int i = 0; i < NUM_FU; i++) begin
            w_fire_fu[i]  = w_fire && (iss_fu == FU_W'(i));
            w_state_nx[i] = r_state[i];
            w_cnt_nx[i]   = r_cnt[i];
            w_rd_nx[i]    = r_rd[i];
            w_we_nx[i]    = r_we[i];
            case (r_state[i])
                S_EXEC: begin
                    if (r_cnt[i] <= LAT_W'(1)) begin
                        w_state_nx[i] = S_DONE;
                        w_cnt_nx[i]   = '0;
                    end else begin
                        w_cnt_nx[i] = r_cnt[i] - LAT_W'(1);
                    end
                end
                S_DONE: begin
                    if (wb_valid && (w_win == FU_W'(i)))
                        w_state_nx[i] = S_IDLE;
                end
                default: w_state_nx[i] = r_state[i];
            endcase
            // The counter holds latency-1 and the unit leaves EXEC as it reaches
            // 1, so an op fired in cycle T is DONE in cycle T+L; L<=1 skips EXEC.
            if (w_fire_fu[i]) begin
                w_rd_nx[i] = iss_rd;
                w_we_nx[i] = iss_rd_we;
                if (w_lat_m1 == '0) begin
                    w_state_nx[i] = S_DONE;
                    w_cnt_nx[i]   = '0;
                end else begin
                    w_state_nx[i] = S_EXEC;
                    w_cnt_nx[i]   = w_lat_m1;
                end
            end
            if (flush) begin
                w_state_nx[i] = S_IDLE;
                w_cnt_nx[i]   = '0;
                w_rd_nx[i]    = '0;
                w_we_nx[i]    = 1'b0;
            end
        end
    end

    always_comb begin
        w_pending_nx = r_pending & ~w_clr_mask;
        if (w_fire && iss_rd_we && (iss_rd != 5'd0))
            w_pending_nx[iss_rd] = 1'b1;
        w_pending_nx[0] = 1'b0;
        if (flush)
            w_pending_nx = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_FU; i++) begin
                r_state[i] <= S_IDLE;
                r_cnt[i]   <= '0;
                r_rd[i]    <= '0;
                r_we[i]    <= 1'b0;
            end
            r_pending <= '0;
        end else begin
            for (int i = 0; i < NUM_FU; i++) begin
                r_state[i] <= w_state_nx[i];
                r_cnt[i]   <= w_cnt_nx[i];
                r_rd[i]    <= w_rd_nx[i];
                r_we[i]    <= w_we_nx[i];
            end
            r_pending <= w_pending_nx;
        end
    end

    always_comb begin
        fu_busy = '0;
        for (int i = 0; i < NUM_FU; i++)
            fu_busy[i] = (r_state[i] != S_IDLE);
    end

endmodule
